// File: rtl/tpx3_rx_pkg.sv
// Shared constants and types for the 8b/10b receive path.
package tpx3_rx_pkg;

  localparam int SYM_W = 10;

  // K28.5 in both running disparities, bit0 = first bit on the wire
  localparam logic [SYM_W-1:0] K285P = 10'b0101111100;
  localparam logic [SYM_W-1:0] K285N = 10'b1010000011;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_t;

  function automatic logic is_k285(input logic [SYM_W-1:0] s);
    return (s == K285P) || (s == K285N);
  endfunction

endpackage

// File: rtl/rx_comma_detect.sv
// Serial-in shift register with a comma compare on the freshly shifted window.
module rx_comma_detect
  import tpx3_rx_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             rx_bit,
  output logic [SYM_W-1:0] sr,
  output logic [SYM_W-1:0] sym,
  output logic             comma
);

  // Window as it will look after this edge; the FSM acts on it in the same edge.
  assign sym   = {rx_bit, sr[SYM_W-1:1]};
  assign comma = is_k285(sym);

  // Shift one bit per edge, newest bit enters at the MSB.
  always_ff @(posedge CLK) begin
    if (RESET) sr <= '0;
    else       sr <= sym;
  end

endmodule

// File: rtl/rx_word_align.sv
// Comma-based word aligner: HUNT -> VERIFY -> LOCKED, emits one symbol per 10 bits.
module rx_word_align
  import tpx3_rx_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RX_BIT,
  output logic [SYM_W-1:0] DATA_OUT,
  output logic             DATA_VALID,
  output logic             IS_COMMA,
  output logic             LOCKED,
  output logic [7:0]       LOSS_CNT
);

  logic [SYM_W-1:0] sr, sym;
  logic             comma;

  align_state_t state, state_n;
  logic [3:0]   cnt, cnt_n;
  logic [7:0]   good, good_n, miss, miss_n;
  logic         pend, pend_n, loss_inc, bnd;

  rx_comma_detect u_det (
    .CLK    (CLK),
    .RESET  (RESET),
    .rx_bit (RX_BIT),
    .sr     (sr),
    .sym    (sym),
    .comma  (comma)
  );

  // Edge where the phase counter sits at 9 closes a symbol.
  assign bnd = (cnt == 4'd9);

  // Next-state, counter and emit decisions.
  always_comb begin
    state_n  = state;
    cnt_n    = bnd ? 4'd0 : cnt + 4'd1;
    good_n   = good;
    miss_n   = miss;
    pend_n   = 1'b0;
    loss_inc = 1'b0;
    case (state)
      ST_HUNT: begin
        if (comma) begin
          cnt_n   = 4'd0;
          good_n  = 8'd1;
          state_n = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (comma) begin
          if (bnd) begin
            good_n = good + 8'd1;
            if (good + 8'd1 == 8'(LOCK_COUNT)) begin
              state_n = ST_LOCKED;
              miss_n  = 8'd0;
            end
          end else begin
            // comma off-phase: restart the count from this new phase
            cnt_n  = 4'd0;
            good_n = 8'd1;
          end
        end
      end
      ST_LOCKED: begin
        // the symbol just completed is presented one edge later
        pend_n = bnd;
        if (comma) begin
          if (bnd) begin
            miss_n = 8'd0;
          end else if (miss + 8'd1 == 8'(UNLOCK_COUNT)) begin
            state_n  = ST_HUNT;
            miss_n   = 8'd0;
            good_n   = 8'd0;
            loss_inc = 1'b1;
          end else begin
            // phase is kept; only repeated misses drop lock
            miss_n = miss + 8'd1;
          end
        end
      end
      default: state_n = ST_HUNT;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_HUNT;
      cnt        <= 4'd0;
      good       <= 8'd0;
      miss       <= 8'd0;
      pend       <= 1'b0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      IS_COMMA   <= 1'b0;
      LOCKED     <= 1'b0;
      LOSS_CNT   <= 8'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      good       <= good_n;
      miss       <= miss_n;
      pend       <= pend_n;
      DATA_VALID <= pend;
      if (pend) begin
        DATA_OUT <= sr;
        IS_COMMA <= is_k285(sr);
      end
      LOCKED <= (state_n == ST_LOCKED);
      if (loss_inc && (LOSS_CNT != 8'hFF)) LOSS_CNT <= LOSS_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_rx_word_align.sv
// Bench for rx_word_align: scenario table, hand sequences, random mix vs reference model.
module tb_rx_word_align;

  localparam int LOCK_COUNT   = 4;
  localparam int UNLOCK_COUNT = 3;
  localparam logic [9:0] TB_KP = 10'b0101111100;
  localparam logic [9:0] TB_KN = 10'b1010000011;
  localparam logic [9:0] D020P = 10'b1101010010;
  localparam logic [9:0] D010P = 10'b1101010001;

  localparam int OP_COMMA = 0, OP_DEL = 1, OP_INS = 2, OP_SLIP = 3, OP_RESET = 4, OP_DATA = 5;

  logic       CLK = 1'b0;
  logic       RESET, RX_BIT;
  logic [9:0] DATA_OUT;
  logic       DATA_VALID, IS_COMMA, LOCKED;
  logic [7:0] LOSS_CNT;

  always #5 CLK = ~CLK;

  rx_word_align #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT)) dut (
    .CLK(CLK), .RESET(RESET), .RX_BIT(RX_BIT), .DATA_OUT(DATA_OUT),
    .DATA_VALID(DATA_VALID), .IS_COMMA(IS_COMMA), .LOCKED(LOCKED), .LOSS_CNT(LOSS_CNT)
  );

  int n_cmp = 0, n_bad = 0;

  // ---------------- reference model ----------------
  typedef enum int {M_HUNT, M_VERIFY, M_LOCKED} mst_t;
  mst_t       m_st;
  bit         q[$];
  longint     m_idx, m_anchor;
  int         m_good, m_miss, m_loss;
  bit         m_locked, m_dv, m_isc, m_pend;
  logic [9:0] m_dout, m_pend_win;

  function automatic void model_reset();
    q.delete();
    for (int k = 0; k < 10; k++) q.push_back(1'b0);
    m_st = M_HUNT; m_idx = 0; m_anchor = 0; m_good = 0; m_miss = 0; m_loss = 0;
    m_locked = 0; m_dv = 0; m_isc = 0; m_pend = 0; m_dout = '0; m_pend_win = '0;
  endfunction

  function automatic void model_edge(input logic b, input logic r);
    logic [9:0] win;
    bit cm, al;
    if (r) begin model_reset(); return; end
    q.push_back(b);
    void'(q.pop_front());
    for (int k = 0; k < 10; k++) win[k] = q[k];
    m_idx++;
    cm = (win == TB_KP) || (win == TB_KN);
    al = ((m_idx - m_anchor) % 10) == 0;
    m_dv = 0;
    if (m_pend) begin
      m_dv = 1; m_dout = m_pend_win;
      m_isc = (m_pend_win == TB_KP) || (m_pend_win == TB_KN);
      m_pend = 0;
    end
    case (m_st)
      M_HUNT: if (cm) begin m_anchor = m_idx; m_good = 1; m_st = M_VERIFY; end
      M_VERIFY: if (cm) begin
        if (al) begin
          m_good++;
          if (m_good == LOCK_COUNT) begin m_st = M_LOCKED; m_miss = 0; end
        end else begin
          m_anchor = m_idx; m_good = 1;
        end
      end
      M_LOCKED: begin
        if (al) begin m_pend = 1; m_pend_win = win; end
        if (cm) begin
          if (al) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss == UNLOCK_COUNT) begin
              m_st = M_HUNT; m_miss = 0;
              if (m_loss < 255) m_loss++;
            end
          end
        end
      end
      default: m_st = M_HUNT;
    endcase
    m_locked = (m_st == M_LOCKED);
  endfunction

  // ---------------- bench plumbing ----------------
  int         tb_edges = 0, rise_edge = -1, first_dv = -1, last_dv = -1;
  bit         prev_locked = 0, logging = 0, nxt_p = 1;
  logic [9:0] last_dout;
  bit         last_isc;
  logic [10:0] dv_log[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input logic b, input logic r);
    RX_BIT = b; RESET = r;
    @(posedge CLK);
    model_edge(b, r);
    #1;
    tb_edges++;
    check("cycle", {11'd0, DATA_OUT, DATA_VALID, IS_COMMA, LOCKED, LOSS_CNT},
                   {11'd0, m_dout, m_dv, m_isc, m_locked, m_loss[7:0]});
    if (LOCKED && !prev_locked) rise_edge = tb_edges;
    prev_locked = LOCKED;
    if (DATA_VALID) begin
      last_dout = DATA_OUT; last_isc = IS_COMMA;
      if (first_dv < 0) first_dv = tb_edges;
      if (logging) dv_log.push_back({IS_COMMA, DATA_OUT});
      if (last_dv >= 0) check("dv_spacing", tb_edges - last_dv, 10);
      last_dv = tb_edges;
    end
    if (!LOCKED) last_dv = -1;
  endtask

  task automatic send_sym(input logic [9:0] s, input int from);
    for (int k = from; k < 10; k++) tick(s[k], 1'b0);
  endtask

  task automatic send_comma();
    send_sym(nxt_p ? TB_KP : TB_KN, 0);
    nxt_p = !nxt_p;
  endtask

  // comma with its first bit dropped: later symbols arrive one bit early
  task automatic send_del();
    send_sym(nxt_p ? TB_KP : TB_KN, 1);
    nxt_p = !nxt_p;
  endtask

  task automatic apply_op(input int op, input int n);
    case (op)
      OP_COMMA: repeat (n) send_comma();
      OP_DEL:   repeat (n) send_del();
      OP_INS:   repeat (n) tick(1'b0, 1'b0);
      OP_SLIP:  repeat (n) tick(1'($urandom_range(0, 1)), 1'b0);
      OP_RESET: begin tick(1'b0, 1'b1); nxt_p = 1; end
      OP_DATA:  repeat (n) begin send_sym(D020P, 0); send_sym(D010P, 0); end
      default:  ;
    endcase
  endtask

  typedef struct {
    string name;
    int    op;
    int    n;
    bit    exp_locked;
    int    exp_loss;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int start;
    model_reset();
    RX_BIT = 1'b0; RESET = 1'b1;

    // reset state
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("reset_outputs", {11'd0, DATA_OUT, DATA_VALID, IS_COMMA, LOCKED, LOSS_CNT}, 32'd0);

    // 30 comma pairs then data: lock latency, first strobe, content
    nxt_p = 1; start = tb_edges; rise_edge = -1; first_dv = -1;
    apply_op(OP_COMMA, 60);
    check("lock_latency", rise_edge - start, 40);
    check("first_dv", first_dv - start, 51);
    dv_log.delete(); logging = 1;
    apply_op(OP_DATA, 20);
    logging = 0;
    check("dv_count", dv_log.size(), 40);
    if (dv_log.size() == 40) begin
      check("dv_last_comma", dv_log[0], {1'b1, TB_KN});
      for (int k = 1; k < 40; k++)
        check("dv_data", dv_log[k], {1'b0, (k % 2 == 1) ? D020P : D010P});
    end

    // scenario table: LOCKED / LOSS_CNT after each step
    tbl.push_back('{"slip_del",        OP_DEL,   1, 1'b1, 0});
    tbl.push_back('{"slip_miss2",      OP_COMMA, 2, 1'b1, 0});
    tbl.push_back('{"slip_miss3",      OP_COMMA, 1, 1'b0, 1});
    tbl.push_back('{"relock_3",        OP_COMMA, 3, 1'b0, 1});
    tbl.push_back('{"relock_4",        OP_COMMA, 1, 1'b1, 1});
    tbl.push_back('{"one_miss_del",    OP_DEL,   1, 1'b1, 1});
    tbl.push_back('{"one_miss",        OP_COMMA, 1, 1'b1, 1});
    tbl.push_back('{"one_miss_ins",    OP_INS,   1, 1'b1, 1});
    tbl.push_back('{"realigned",       OP_COMMA, 4, 1'b1, 1});
    tbl.push_back('{"miss_clr_del",    OP_DEL,   1, 1'b1, 1});
    tbl.push_back('{"miss_clr_two",    OP_COMMA, 2, 1'b1, 1});
    tbl.push_back('{"miss_clr_ins",    OP_INS,   1, 1'b1, 1});
    tbl.push_back('{"miss_clr_align",  OP_COMMA, 2, 1'b1, 1});
    tbl.push_back('{"reset_locked",    OP_RESET, 1, 1'b0, 0});
    tbl.push_back('{"bitslip_3",       OP_SLIP,  3, 1'b0, 0});
    tbl.push_back('{"bitslip_hunt",    OP_COMMA, 3, 1'b0, 0});
    tbl.push_back('{"bitslip_lock",    OP_COMMA, 1, 1'b1, 0});
    tbl.push_back('{"bitslip_run",     OP_COMMA, 4, 1'b1, 0});
    foreach (tbl[i]) begin
      apply_op(tbl[i].op, tbl[i].n);
      check({tbl[i].name, "_locked"}, LOCKED, tbl[i].exp_locked);
      check({tbl[i].name, "_loss"}, LOSS_CNT, tbl[i].exp_loss);
    end
    check("bitslip_dout", last_dout, TB_KP);
    check("bitslip_isc", last_isc, 1);

    // reset pulse while locked, then relock with the same latency
    tick(1'b0, 1'b1); nxt_p = 1;
    check("reset_pulse_out", {11'd0, DATA_OUT, DATA_VALID, IS_COMMA, LOCKED, LOSS_CNT}, 32'd0);
    start = tb_edges; rise_edge = -1;
    apply_op(OP_COMMA, 6);
    check("relock_latency", rise_edge - start, 40);

    // 256 lock losses: counter saturates
    for (int i = 0; i < 256; i++) begin
      send_del();
      apply_op(OP_COMMA, 3);
      if (i == 253) check("loss_254", LOSS_CNT, 254);
      apply_op(OP_COMMA, 4);
    end
    check("loss_sat", LOSS_CNT, 255);
    check("loss_sat_locked", LOCKED, 1);

    // randomized mix against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      apply_op(OP_COMMA, 1);
      else if (r < 65) apply_op(OP_DATA, 1);
      else if (r < 78) apply_op(OP_SLIP, $urandom_range(1, 9));
      else if (r < 90) apply_op(OP_DEL, 1);
      else if (r < 98) apply_op(OP_INS, 1);
      else             apply_op(OP_RESET, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
